time_set_editor: RTL
====================

TIME_SET_EDITOR -- requirements
Module: time_set_editor

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000: number of stable CLK cycles a raw button must hold before its level is accepted.
REQ-002 SHALL have the following ports:
- CLK  in  1  system clock.
- RESETN  in  1  reset; synchronous, active-low, sampled on CLK.
- MODE  in  2  display mode: 00 NONE, 01 NOW, 10 ARM, 11 treated as NONE.
- BTN_UP, BTN_DOWN, BTN_SHIFT, BTN_OK  in  1 each  raw asynchronous push buttons, active-high.
- HOUR, MIN, SEC  in  7 each  live running time, binary.
- SET_HOUR, SET_MIN, SET_SEC  out  7 each  edit buffer for the current time.
- ARM_HOUR, ARM_MIN, ARM_SEC  out  7 each  alarm time registers.
- SHIFT_NOW  out  4  cursor: 0 none, 1 hour, 2 min, 3 sec.
- LOAD  out  1  one-cycle pulse telling the watch counter to take SET_*.
- ARM_VALID  out  1  high once an alarm time has been committed.

Function
REQ-003 SHALL pass every button through a 2-FF synchronizer and a debouncer, then raise a one-cycle press pulse on the accepted 0->1 transition; a held button SHALL produce exactly one pulse.
REQ-004 SHALL implement a state machine with states IDLE, EDIT_NOW, EDIT_ARM and DONE.
REQ-005 IDLE->EDIT_NOW when MODE becomes 01:
- SET_* SHALL load HOUR/MIN/SEC in the same cycle.
- SHIFT_NOW SHALL become 1.
REQ-006 IDLE->EDIT_ARM when MODE becomes 10: ARM_* SHALL be kept and SHIFT_NOW SHALL become 1.
REQ-007 In EDIT states, a shift pulse SHALL advance the cursor 1->2->3->1.
REQ-008 In EDIT states, an up pulse SHALL increment the selected field of the active bank. Wrap: hour 23->0, min/sec 59->0.
REQ-009 In EDIT states, a down pulse SHALL decrement the selected field. Wrap: hour 0->23, min/sec 0->59.
REQ-010 Up and down pulses in the same cycle SHALL both be ignored.
REQ-011 Up or down in the same cycle as shift SHALL apply to the field selected before the shift; the cursor advances afterwards.
REQ-012 An OK pulse in EDIT_NOW SHALL assert LOAD for exactly the next cycle, set SHIFT_NOW to 0 and enter DONE.
REQ-013 An OK pulse in EDIT_ARM SHALL set ARM_VALID to 1, set SHIFT_NOW to 0 and enter DONE; LOAD SHALL stay 0.
REQ-014 DONE SHALL ignore all buttons and return to IDLE when MODE changes.
REQ-015 A MODE change during an EDIT state SHALL abandon the edit:
- no LOAD, no ARM_VALID change;
- the edited ARM_* values are retained;
- the next state follows the new MODE per REQ-005/006, otherwise IDLE.
REQ-016 In IDLE, SET_* SHALL track HOUR/MIN/SEC every cycle; SHIFT_NOW SHALL be 0.
REQ-017 All outputs SHALL be registered; field values SHALL never exceed 23 (hour) or 59 (min/sec).

Reset
REQ-018 When RESETN=0 at a CLK edge, the block SHALL apply:
- state IDLE; SET_* and ARM_* = 0; SHIFT_NOW = 0; LOAD = 0; ARM_VALID = 0;
- debouncers cleared to "released", so no pulse is generated at reset release.
REQ-019 Reset SHALL take priority over every other event, including a pending LOAD.

Configuration
REQ-020 With ALARM_EDIT_EN defined, the alarm bank, EDIT_ARM state and ARM_VALID SHALL be present.
REQ-021 Without ALARM_EDIT_EN:
- ARM_* SHALL be tied to 0 and ARM_VALID tied to 0;
- MODE=10 SHALL be treated as NONE;
- the port list is unchanged.

Structure
REQ-022 A shared package SHALL hold:
- MODE encodings;
- state enumeration;
- cursor codes 0-3;
- limits HOUR_MAX=23 and MINSEC_MAX=59.
REQ-023 The synchronizer, debouncer and edge detector SHALL be one sub-module, btn_cond, instantiated four times.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset; HOUR/MIN/SEC=10/20/30, MODE=01 -> SET_*=10/20/30, SHIFT_NOW=1.
- In EDIT_NOW with SET_HOUR=23, up -> 0; cursor on min with SET_MIN=0, down -> 59.
- Set 12:34:56, OK -> LOAD high for exactly one cycle, SHIFT_NOW=0, state DONE.
- Up and down in the same cycle -> no field change; shift with up on hour=5 -> hour=6, SHIFT_NOW=2.
- BTN_UP bouncing for less than DEB_CYCLES, then held for 3*DEB_CYCLES -> exactly one increment.
- MODE=10 (ALARM_EDIT_EN): set 07:00:00, OK -> ARM_*=7/0/0, ARM_VALID=1; MODE 01->00 mid-edit -> no LOAD.

Source files
------------

// File: rtl/time_set_editor_pkg.sv
// Shared encodings, limits and helpers for the time/alarm set editor.
// Optional alarm bank is enabled by defining ALARM_EDIT_EN.
package time_set_editor_pkg;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_NOW  = 2'b01;
    localparam logic [1:0] MODE_ARM  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EDIT_NOW,
        ST_EDIT_ARM,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_NOW,
        TGT_ARM
    } target_e;

    localparam logic [3:0] CUR_NONE = 4'd0;
    localparam logic [3:0] CUR_HOUR = 4'd1;
    localparam logic [3:0] CUR_MIN  = 4'd2;
    localparam logic [3:0] CUR_SEC  = 4'd3;

    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] MINSEC_MAX = 7'd59;

`ifdef ALARM_EDIT_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    function automatic target_e decode_mode(input logic [1:0] m);
        target_e t;
        t = TGT_NONE;
        case (m)
            MODE_NOW: t = TGT_NOW;
            MODE_ARM: t = ALARM_EN ? TGT_ARM : TGT_NONE;
            default:  t = TGT_NONE;
        endcase
        return t;
    endfunction

    function automatic logic [6:0] wrap_inc(input logic [6:0] v,
                                            input logic [6:0] mx);
        return (v >= mx) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] wrap_dec(input logic [6:0] v,
                                            input logic [6:0] mx);
        return (v == 7'd0 || v > mx) ? mx : v - 7'd1;
    endfunction

    function automatic logic [6:0] clamp(input logic [6:0] v,
                                         input logic [6:0] mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [3:0] next_cursor(input logic [3:0] c);
        logic [3:0] n;
        case (c)
            CUR_HOUR: n = CUR_MIN;
            CUR_MIN:  n = CUR_SEC;
            default:  n = CUR_HOUR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/time_set_editor_btn_cond.sv
// Button conditioner: 2-FF synchronizer, debouncer, rising-edge pulse.
// A level must differ from the accepted level for DEB_CYCLES cycles.
module btn_cond #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Synchronize, qualify a stable level, pulse on accepted rise.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/time_set_editor.sv
// Time / alarm set editor driven by four push buttons.
// Alarm bank and EDIT_ARM are present only with ALARM_EDIT_EN defined.
module time_set_editor
    import time_set_editor_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [1:0] MODE,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_SHIFT,
    input  logic       BTN_OK,
    input  logic [6:0] HOUR,
    input  logic [6:0] MIN,
    input  logic [6:0] SEC,
    output logic [6:0] SET_HOUR,
    output logic [6:0] SET_MIN,
    output logic [6:0] SET_SEC,
    output logic [6:0] ARM_HOUR,
    output logic [6:0] ARM_MIN,
    output logic [6:0] ARM_SEC,
    output logic [3:0] SHIFT_NOW,
    output logic       LOAD,
    output logic       ARM_VALID
);

    logic up_p, dn_p, sh_p, ok_p;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_up (
        .CLK(CLK), .RESETN(RESETN), .btn_i(BTN_UP), .press_o(up_p));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
        .CLK(CLK), .RESETN(RESETN), .btn_i(BTN_DOWN), .press_o(dn_p));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_sh (
        .CLK(CLK), .RESETN(RESETN), .btn_i(BTN_SHIFT), .press_o(sh_p));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_ok (
        .CLK(CLK), .RESETN(RESETN), .btn_i(BTN_OK), .press_o(ok_p));

    state_e     state_q;
    target_e    edit_tgt_q;
    logic [6:0] set_hour_q, set_min_q, set_sec_q;
    logic [3:0] cursor_q;
    logic       load_q;

`ifdef ALARM_EDIT_EN
    logic [6:0] arm_hour_q, arm_min_q, arm_sec_q;
    logic       arm_valid_q;
    assign ARM_HOUR  = arm_hour_q;
    assign ARM_MIN   = arm_min_q;
    assign ARM_SEC   = arm_sec_q;
    assign ARM_VALID = arm_valid_q;
`else
    assign ARM_HOUR  = 7'd0;
    assign ARM_MIN   = 7'd0;
    assign ARM_SEC   = 7'd0;
    assign ARM_VALID = 1'b0;
`endif

    target_e    tgt;
    logic       edit_arm;
    logic       step;
    logic [6:0] cur_val;
    logic [6:0] cur_max;
    logic [6:0] new_val;

    assign tgt      = decode_mode(MODE);
    assign edit_arm = (state_q == ST_EDIT_ARM);
    // Simultaneous up and down cancel each other.
    assign step     = up_p ^ dn_p;

    // Select the field under the cursor and compute its wrapped update.
    always_comb begin
        cur_val = 7'd0;
        cur_max = MINSEC_MAX;
        case (cursor_q)
            CUR_HOUR: begin
                cur_val = edit_arm ? ARM_HOUR : set_hour_q;
                cur_max = HOUR_MAX;
            end
            CUR_MIN: cur_val = edit_arm ? ARM_MIN : set_min_q;
            CUR_SEC: cur_val = edit_arm ? ARM_SEC : set_sec_q;
            default: cur_val = 7'd0;
        endcase
        new_val = up_p ? wrap_inc(cur_val, cur_max)
                       : wrap_dec(cur_val, cur_max);
    end

    // Editor state machine with registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            edit_tgt_q <= TGT_NONE;
            set_hour_q <= 7'd0;
            set_min_q  <= 7'd0;
            set_sec_q  <= 7'd0;
            cursor_q   <= CUR_NONE;
            load_q     <= 1'b0;
`ifdef ALARM_EDIT_EN
            arm_hour_q  <= 7'd0;
            arm_min_q   <= 7'd0;
            arm_sec_q   <= 7'd0;
            arm_valid_q <= 1'b0;
`endif
        end else begin
            load_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    set_hour_q <= clamp(HOUR, HOUR_MAX);
                    set_min_q  <= clamp(MIN, MINSEC_MAX);
                    set_sec_q  <= clamp(SEC, MINSEC_MAX);
                    cursor_q   <= CUR_NONE;
                    if (tgt == TGT_NOW) begin
                        state_q    <= ST_EDIT_NOW;
                        edit_tgt_q <= TGT_NOW;
                        cursor_q   <= CUR_HOUR;
                    end else if (tgt == TGT_ARM) begin
                        state_q    <= ST_EDIT_ARM;
                        edit_tgt_q <= TGT_ARM;
                        cursor_q   <= CUR_HOUR;
                    end
                end
                ST_EDIT_NOW, ST_EDIT_ARM: begin
                    if (tgt != edit_tgt_q) begin
                        // Mode changed: drop the edit, keep edited values.
                        edit_tgt_q <= tgt;
                        if (tgt == TGT_NOW) begin
                            state_q    <= ST_EDIT_NOW;
                            cursor_q   <= CUR_HOUR;
                            set_hour_q <= clamp(HOUR, HOUR_MAX);
                            set_min_q  <= clamp(MIN, MINSEC_MAX);
                            set_sec_q  <= clamp(SEC, MINSEC_MAX);
                        end else if (tgt == TGT_ARM) begin
                            state_q  <= ST_EDIT_ARM;
                            cursor_q <= CUR_HOUR;
                        end else begin
                            state_q  <= ST_IDLE;
                            cursor_q <= CUR_NONE;
                        end
                    end else if (ok_p) begin
                        state_q  <= ST_DONE;
                        cursor_q <= CUR_NONE;
                        if (!edit_arm) begin
                            load_q <= 1'b1;
                        end
`ifdef ALARM_EDIT_EN
                        else begin
                            arm_valid_q <= 1'b1;
                        end
`endif
                    end else begin
                        if (step) begin
                            case (cursor_q)
                                CUR_HOUR: begin
`ifdef ALARM_EDIT_EN
                                    if (edit_arm) arm_hour_q <= new_val;
                                    else
`endif
                                    set_hour_q <= new_val;
                                end
                                CUR_MIN: begin
`ifdef ALARM_EDIT_EN
                                    if (edit_arm) arm_min_q <= new_val;
                                    else
`endif
                                    set_min_q <= new_val;
                                end
                                CUR_SEC: begin
`ifdef ALARM_EDIT_EN
                                    if (edit_arm) arm_sec_q <= new_val;
                                    else
`endif
                                    set_sec_q <= new_val;
                                end
                                default: ;
                            endcase
                        end
                        // Cursor moves after the edit of this cycle.
                        if (sh_p) begin
                            cursor_q <= next_cursor(cursor_q);
                        end
                    end
                end
                ST_DONE: begin
                    if (tgt != edit_tgt_q) begin
                        state_q    <= ST_IDLE;
                        edit_tgt_q <= TGT_NONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SET_HOUR  = set_hour_q;
    assign SET_MIN   = set_min_q;
    assign SET_SEC   = set_sec_q;
    assign SHIFT_NOW = cursor_q;
    assign LOAD      = load_q;

endmodule
